fetch_unit: RTL

- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues in-order word requests to instruction memory over a req/gnt/rvalid bus.
- Buffers returned words in a small prefetch FIFO and presents {pc, instruction} to decode with a valid/ready handshake.
- Accepts a redirect (taken branch/jump) from EX/MEM. On redirect it flushes buffered words and discards in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 47 ++++
 rtl/fetch_unit_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch front end.
// NOP encoding, default boot address and fetch FSM states.
package fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect, instruction memory and decode sides.
// master is the fetch unit, slave is memory/decode/EX.
interface fetch_unit_if #(
  parameter int AW = 32
);

  logic          i_redirect;
  logic [AW-1:0] i_redirect_pc;
  logic          o_imem_req;
  logic [AW-1:0] o_imem_addr;
  logic          i_imem_gnt;
  logic          i_imem_rvalid;
  logic [31:0]   i_imem_rdata;
  logic          o_valid;
  logic [AW-1:0] o_pc;
  logic [31:0]   o_instr;
  logic          i_ready;

  modport master (
    input  i_redirect,
    input  i_redirect_pc,
    input  i_imem_gnt,
    input  i_imem_rvalid,
    input  i_imem_rdata,
    input  i_ready,
    output o_imem_req,
    output o_imem_addr,
    output o_valid,
    output o_pc,
    output o_instr
  );

  modport slave (
    output i_redirect,
    output i_redirect_pc,
    output i_imem_gnt,
    output i_imem_rvalid,
    output i_imem_rdata,
    output i_ready,
    input  o_imem_req,
    input  o_imem_addr,
    input  o_valid,
    input  o_pc,
    input  o_instr
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} with push/pop/flush.
// Head entry is read combinationally; flush wins over push.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [AW-1:0]          push_pc,
  input  logic [31:0]            push_instr,
  input  logic                   pop,
  input  logic                   flush,
  output logic [AW-1:0]          head_pc,
  output logic [31:0]            head_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push)
                     - (PW+1)'(do_pop);
    end
  end

  // storage needs no reset: entries are only read when count != 0
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]  <= push_pc;
      ins_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = ins_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, in-order imem requests,
// prefetch buffering and redirect with stale-response discard.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input logic          i_clk,
  input logic          i_reset_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] resp_pc;
  logic [AW-1:0] target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [CW:0]   inflight;
  logic          req;
  logic          gnt_fire;
  logic          rsp;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW-1:0] head_pc;
  logic [31:0]   head_instr;

  assign target   = bus.i_redirect_pc & ~AW'(3);
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign req      = (state == FETCH)
                 && (inflight < (CW+1)'(DEPTH));
  assign gnt_fire = req && bus.i_imem_gnt;
  assign rsp      = bus.i_imem_rvalid;
  // a response landing with a redirect belongs to the old stream
  assign push     = rsp && (discard == '0)
                 && !bus.i_redirect;
  assign pop      = !empty && bus.i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      unique case (state)
        BOOT:  state <= FETCH;
        FETCH: state <= FETCH;
      endcase
      outstanding <= outstanding + CW'(gnt_fire)
                                 - CW'(rsp);
      if (bus.i_redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        discard  <= outstanding + CW'(gnt_fire)
                                - CW'(rsp);
      end else begin
        if (gnt_fire) fetch_pc <= fetch_pc + AW'(4);
        if (push)     resp_pc  <= resp_pc + AW'(4);
        if (rsp && discard != '0)
          discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .push       (push),
    .push_pc    (resp_pc),
    .push_instr (bus.i_imem_rdata),
    .pop        (pop),
    .flush      (bus.i_redirect),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = fetch_pc;
  assign bus.o_valid     = !empty;
  assign bus.o_pc        = empty ? '0 : head_pc;
  assign bus.o_instr     = empty ? NOP : head_instr;

  a_no_overflow: assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
    !(push && full)
  );

endmodule
